// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder.
//   state_e    : controller state encoding
//   cnt_width(): digit-counter width for a given WIDTH/DIGIT pair
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  // The counter has to hold indices 0..N-1. It is never narrower than one
  // bit, so that N=1 (DIGIT == WIDTH) still elaborates a real register.
  function automatic int cnt_width(input int width, input int digit);
    int n;
    n = width / digit;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_serial_adder_fa_slice.sv
// Combinational DIGIT-bit ripple-carry slice built from one-bit full adders.
//   a_i, b_i : operand digits
//   cin_i    : carry into bit 0
//   s_o      : digit sum
//   cout_o   : carry out of the slice MSB
//   c_msb_o  : carry into the slice MSB. XOR with cout_o gives signed overflow
//              when this slice holds the operand MSB.
module fa_slice #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] s_o,
  output logic             cout_o,
  output logic             c_msb_o
);

  logic [DIGIT:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o  = c[DIGIT];
  assign c_msb_o = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial two's-complement adder/subtractor.
// The operands are captured in a single cycle. They are then summed DIGIT
// bits per clock, LSB digit first, through one fa_slice and a registered
// carry. The result is held until the consumer accepts it.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset
//   in_valid_i   : operand request
//   in_ready_o   : ready for operands (IDLE only)
//   a_i, b_i     : operands
//   cin_i        : carry-in (add) / borrow-in (subtract)
//   sub_i        : 0 = a+b+cin, 1 = a-b-cin
//   out_valid_o  : result held (DONE only)
//   out_ready_i  : consumer accepts result
//   sum_o        : result
//   cout_o       : raw adder carry-out. For subtract, 1 = no borrow.
//   ovf_o        : signed overflow
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for operands, in_ready_o high
// BUSY  | one digit per cycle through the slice, N cycles in total
// DONE  | result frozen, out_valid_o high until out_ready_i
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(WIDTH, DIGIT);

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
    $fatal(1, "digit_serial_adder: DIGIT must divide WIDTH and lie in 1..WIDTH");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0] slice_s;
  logic             slice_cout;
  logic             slice_cmsb;
  logic [WIDTH-1:0] sum_shift;
  logic             accept;
  logic             busy;
  logic             last;

  assign accept = in_valid_i && (state_q == IDLE);
  assign busy   = (state_q == BUSY);
  assign last   = (cnt_q == CW'(N - 1));

  fa_slice #(.DIGIT(DIGIT)) u_slice (
    .a_i    (a_q[DIGIT-1:0]),
    .b_i    (b_q[DIGIT-1:0]),
    .cin_i  (carry_q),
    .s_o    (slice_s),
    .cout_o (slice_cout),
    .c_msb_o(slice_cmsb)
  );

  // Each new digit enters at the top of the result register. After N steps
  // the first digit has reached bit 0.
  if (DIGIT == WIDTH) begin : g_full_slice
    assign sum_shift = slice_s;
  end else begin : g_part_slice
    assign sum_shift = {slice_s, sum_q[WIDTH-1:DIGIT]};
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid_i)  state_d = BUSY;
      BUSY:    if (last)        state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Handshake outputs come straight from the state register.
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    unique case (state_q)
      IDLE:    in_ready_o  = 1'b1;
      DONE:    out_valid_o = 1'b1;
      default: ;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    if (accept) begin
      // Subtraction is a + ~b + 1. The inverted b is stored, and sub is
      // folded into the initial carry. With cin then a - b - cin.
      a_d     = a_i;
      b_d     = b_i ^ {WIDTH{sub_i}};
      carry_d = cin_i ^ sub_i;
      cnt_d   = '0;
    end else if (busy) begin
      a_d     = a_q >> DIGIT;
      b_d     = b_q >> DIGIT;
      sum_d   = sum_shift;
      carry_d = slice_cout;
      if (last) begin
        cnt_d  = '0;
        cout_d = slice_cout;
        ovf_d  = slice_cout ^ slice_cmsb;
      end else begin
        cnt_d  = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
module tb_digit_serial_adder;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        v;
    int          acc;
  } exp_t;

  logic clk;
  int   cyc;
  int   n_cmp;
  int   n_fail;

  initial begin
    clk    = 1'b0;
    cyc    = 0;
    n_cmp  = 0;
    n_fail = 0;
  end
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int wof(input int g);
    case (g)
      0: return 8;
      1: return 8;
      2: return 8;
      3: return 16;
      default: return 12;
    endcase
  endfunction

  function automatic int dof(input int g);
    case (g)
      0: return 2;
      1: return 1;
      2: return 8;
      3: return 4;
      default: return 3;
    endcase
  endfunction

  for (genvar g = 0; g < 5; g++) begin : g_inst
    localparam int W = wof(g);
    localparam int D = dof(g);
    localparam int N = W / D;

    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    bit           done_f;
    exp_t         q[$];

    digit_serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .a_i        (a),
      .b_i        (b),
      .cin_i      (cin),
      .sub_i      (sub),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .sum_o      (sum),
      .cout_o     (cout),
      .ovf_o      (ovf)
    );

    // Reference: full-width add of a, (b or ~b), and the folded carry.
    function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                           input logic ci, input logic sb);
      logic [W-1:0] bb;
      logic [W:0]   full;
      logic         v;
      bb   = bv ^ {W{sb}};
      full = {1'b0, av} + {1'b0, bb} + {{W{1'b0}}, ci ^ sb};
      v    = (av[W-1] == bb[W-1]) && (full[W-1] != av[W-1]);
      return {v, full};
    endfunction

    // Present operands, push the expectation, and return just after the
    // accepting edge with in_valid dropped and the operand inputs scrambled.
    task automatic start(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                         input logic sb, input logic [W-1:0] es, input logic ec,
                         input logic ev, input bit push);
      int budget;
      budget = 100;
      @(negedge clk);
      a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
      while (!in_ready && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (budget == 0) chk($sformatf("i%0d in_ready_timeout", g), 0, 1);
      if (push) q.push_back('{s: 16'(es), c: ec, v: ev, acc: cyc});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = ~av; b = ~bv; cin = ~ci; sub = ~sb;
    endtask

    task automatic finish(input int stall);
      int budget;
      budget = 100;
      while (!out_valid && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (budget == 0) chk($sformatf("i%0d out_valid_timeout", g), 0, 1);
      repeat (stall) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    endtask

    task automatic reset_check();
      chk($sformatf("i%0d rst in_ready", g), in_ready, 1);
      chk($sformatf("i%0d rst out_valid", g), out_valid, 0);
      chk($sformatf("i%0d rst sum", g), sum, 0);
      chk($sformatf("i%0d rst cout", g), cout, 0);
      chk($sformatf("i%0d rst ovf", g), ovf, 0);
    endtask

    // Monitor: latency on the rising edge of out_valid, result on handshake.
    initial begin
      bit prev;
      prev = 1'b0;
      forever begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
          prev = 1'b0;
        end else begin
          if (out_valid && !prev) begin
            chk($sformatf("i%0d scoreboard_nonempty", g), (q.size() != 0), 1);
            if (q.size() != 0)
              chk($sformatf("i%0d latency", g), cyc - q[0].acc, N + 1);
          end
          if (out_valid && out_ready && q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk($sformatf("i%0d sum", g), sum, e.s);
            chk($sformatf("i%0d cout", g), cout, e.c);
            chk($sformatf("i%0d ovf", g), ovf, e.v);
          end
          prev = out_valid;
        end
      end
    end

    // Driver
    initial begin
      done_f    = 1'b0;
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      #1 rst_n = 1'b0;
      #2 reset_check();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      if (g == 0) begin
        logic [W-1:0] s0;
        logic         c0;
        logic         v0;
        int           budget;

        start(8'h3C, 8'h45, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b1); finish(0);
        start(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1); finish(1);
        start(8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1); finish(0);
        start(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b1); finish(2);
        start(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1); finish(0);

        // Backpressure: three stalled DONE cycles with an in_valid pulse.
        start(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
        budget = 100;
        while (!out_valid && budget > 0) begin
          @(negedge clk);
          budget--;
        end
        chk("i0 bp reached_done", out_valid, 1);
        s0 = sum; c0 = cout; v0 = ovf;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          in_valid = (k == 0);
          a = 8'hAA; b = 8'h55;
          #1;
          chk("i0 bp out_valid", out_valid, 1);
          chk("i0 bp sum", sum, s0);
          chk("i0 bp cout", cout, c0);
          chk("i0 bp ovf", ovf, v0);
          chk("i0 bp in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("i0 bp idle in_ready", in_ready, 1);
        chk("i0 bp idle out_valid", out_valid, 0);
        chk("i0 bp sum_persist", sum, 8'h46);
        @(negedge clk);
        #1;
        chk("i0 bp pulse_not_taken", in_ready, 1);

        // Reset during the second BUSY cycle.
        start(8'h55, 8'h22, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("i0 midrst out_valid", out_valid, 0);
        chk("i0 midrst sum", sum, 0);
        chk("i0 midrst in_ready", in_ready, 1);
        chk("i0 midrst cout", cout, 0);
        chk("i0 midrst ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        start(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1); finish(0);
        repeat (2) @(negedge clk);
        chk("i0 sb_drained", q.size(), 0);
      end else begin
        for (int i = 0; i < 1000; i++) begin
          logic [W-1:0] av;
          logic [W-1:0] bv;
          logic         ci;
          logic         sb;
          logic [W+1:0] r;
          av = W'($urandom);
          bv = W'($urandom);
          ci = 1'($urandom);
          sb = 1'($urandom);
          r  = model(av, bv, ci, sb);
          start(av, bv, ci, sb, r[W-1:0], r[W], r[W+1], 1'b1);
          finish($urandom_range(0, 3));
        end
        repeat (2) @(negedge clk);
        chk($sformatf("i%0d sb_drained", g), q.size(), 0);
      end
      done_f = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(g_inst[0].done_f && g_inst[1].done_f && g_inst[2].done_f &&
             g_inst[3].done_f && g_inst[4].done_f) && t < 80000) begin
      @(negedge clk);
      t++;
    end
    chk("all_done", (t < 80000), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

Parametrised digit-serial two's-complement adder/subtractor with valid/ready handshakes on both sides. Operands are accepted in one cycle and added DIGIT bits per clock, LSB digit first, through a single DIGIT-bit ripple slice with a registered carry. The wide result is then held until the consumer takes it. It is the area-lean successor to the one-bit full-adder cell for arithmetic datapaths, and trades latency for a slice whose width is independent of WIDTH.

## Interface
- WIDTH, 8, operand and result width in bits.
- DIGIT, 2, bits processed per cycle. Must divide WIDTH; 1 ≤ DIGIT ≤ WIDTH. N = WIDTH/DIGIT digit steps.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add, borrow-in for subtract.
- sub  input  1  0: a+b+cin; 1: a−b−cin.
- out_valid  output  1  result held; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  raw adder carry-out. For subtract, 1 means no borrow.
- ovf  output  1  signed overflow.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE → BUSY on in_valid && in_ready.
  - Latch a, then b ^ {WIDTH{sub}}.
  - Set carry to cin ^ sub and the digit counter to 0.
- BUSY: each cycle, the slice adds digit k of A, digit k of B' and carry.
  - Its DIGIT-bit result shifts into the top of the sum register, which is a right shift.
  - Carry is updated and the counter increments.
- BUSY → DONE after the cycle that processes digit N−1.
  - cout takes the final carry.
  - ovf takes carry-into-MSB XOR carry-out-of-MSB, taken from the last digit.
- DONE → IDLE on out_valid && out_ready.
- Operand inputs are sampled only at acceptance. Later changes have no effect.
- in_valid is ignored outside IDLE. No operation is lost or queued.
- sum, cout and ovf are stable throughout DONE.
  - sum changes during BUSY and is meaningful only while out_valid=1.
  - Values persist after the handshake until the next operation begins shifting.
- Counter width is max(1, $clog2(N)). It wraps to 0 on the BUSY → DONE transition.
- DIGIT=WIDTH (N=1) is legal: BUSY lasts one cycle.

## Timing
- Reset (rst_n low, any state, including mid-BUSY):
  - Immediately: state IDLE, in_ready=1, out_valid=0.
  - sum=0, cout=0, ovf=0, carry=0, counter=0.
  - The in-flight operation is discarded.
  - Handshakes are ignored while rst_n is low.
- Latency: acceptance in cycle 0 → BUSY in cycles 1..N → out_valid=1 from cycle N+1.
- Minimum operation period is N+2 cycles. There is one IDLE cycle after each DONE handshake; no same-cycle turnaround.
- Backpressure: DONE is held indefinitely while out_ready=0, with outputs frozen.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready to either.
- The critical path is DIGIT full-adder stages plus the carry flop, independent of WIDTH.

## Structure
- Shared package `adder_pkg`:
  - State enum: IDLE=2'b00, BUSY=2'b01, DONE=2'b10.
  - Function computing the counter width from WIDTH and DIGIT.
- Sub-module `fa_slice #(DIGIT)`: purely combinational ripple chain of one-bit full-adder cells.
  - Inputs: a, b, cin.
  - Outputs: s[DIGIT], cout, c_msb (carry into the slice MSB, for ovf).
- Top level holds the FSM, operand shift registers, carry flop, counter and result register.
- Elaboration-time check: WIDTH % DIGIT == 0, otherwise fatal.

## Test plan
- WIDTH=8, DIGIT=2: add 8'h3C+8'h45, cin=0 → sum=8'h81, cout=0, ovf=1; out_valid rises exactly 5 cycles after the accept edge.
- Add 8'hFF+8'h01, cin=0 → sum=8'h00, cout=1, ovf=0. Add 8'h7F+8'h00, cin=1 → sum=8'h80, ovf=1.
- Subtract 8'h10−8'h20, cin=0 → sum=8'hF0, cout=0, ovf=0. Subtract 8'h80−8'h01 → sum=8'h7F, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE → out_valid, sum, cout and ovf constant; in_ready=0; a pulse on in_valid is not accepted. Next out_ready → IDLE the following cycle.
- Reset in the 2nd BUSY cycle → out_valid=0, sum=0, in_ready=1 without waiting for a clock edge. After release, 8'h01+8'h01 → 8'h02.
- Sweep (WIDTH,DIGIT) ∈ {(8,1),(8,8),(16,4),(12,3)}: 1000 random operations each with random sub/cin and random out_ready stalls → every result matches the scoreboard; out_valid latency = N+1.
